// File: rtl/fc_data_mover_nlane_pkg.sv
// fc_pkg: FSM state encodings and lane slicing shared by the FC data mover.
package fc_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  // Lane 0 owns the most significant element of a BRAM word.
  function automatic int slice_lo(input int k, input int n, input int w);
    return (n - k - 1) * w;
  endfunction
endpackage

// File: rtl/fc_data_mover_nlane_if.sv
// fc_data_mover_nlane_if: single-port BRAM bus; master drives address/controls, slave returns q.
interface fc_data_mover_nlane_if #(parameter int AWIDTH = 12, parameter int DWIDTH = 32);
  logic [AWIDTH-1:0] addr;
  logic ce;
  logic we;
  logic [DWIDTH-1:0] d;
  logic [DWIDTH-1:0] q;
  modport master(output addr, ce, we, d, input q);
  modport slave(input addr, ce, we, d, output q);
endinterface

// File: rtl/fc_data_mover_nlane_mac_lane.sv
// fc_mac_lane: one multiply-accumulate lane with selectable signed/unsigned products.
module fc_mac_lane #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_valid,
  input  logic i_signed,
  input  logic [IN_DATA_WIDTH-1:0] i_node,
  input  logic [IN_DATA_WIDTH-1:0] i_wegt,
  output logic [ACC_WIDTH-1:0] o_acc
);
  logic signed [2*IN_DATA_WIDTH-1:0] sprod;
  logic [2*IN_DATA_WIDTH-1:0] uprod;
  logic [ACC_WIDTH-1:0] sext;
  logic [ACC_WIDTH-1:0] uext;
  assign sprod = $signed({{IN_DATA_WIDTH{i_node[IN_DATA_WIDTH-1]}}, i_node}) *
                 $signed({{IN_DATA_WIDTH{i_wegt[IN_DATA_WIDTH-1]}}, i_wegt});
  assign uprod = {{IN_DATA_WIDTH{1'b0}}, i_node} * {{IN_DATA_WIDTH{1'b0}}, i_wegt};
  assign sext = ACC_WIDTH'(sprod);
  assign uext = ACC_WIDTH'(uprod);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) o_acc <= '0;
    else if (i_clr) o_acc <= '0;
    else if (i_valid) o_acc <= o_acc + (i_signed ? sext : uext);
endmodule

// File: rtl/fc_data_mover_nlane.sv
// fc_data_mover_nlane: streams node/weight BRAM words through NUM_LANE MAC lanes and writes each lane result back.
module fc_data_mover_nlane import fc_pkg::*; #(
  parameter int CNT_BIT = 31,
  parameter int NUM_LANE = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic i_signed,
  input  logic [AWIDTH-1:0] i_wr_base,
  output logic o_idle,
  output logic o_read,
  output logic o_write,
  output logic o_done,
  fc_data_mover_nlane_if.master b0,
  fc_data_mover_nlane_if.master b1,
  fc_data_mover_nlane_if.master b2,
  output logic [NUM_LANE*ACC_WIDTH-1:0] o_result
);
  localparam int WW = NUM_LANE > 1 ? $clog2(NUM_LANE) : 1;
  logic [2:0] state, next;
  logic [CNT_BIT-1:0] rd_cnt, num_cnt;
  logic [WW-1:0] wr_cnt;
  logic [AWIDTH-1:0] wr_base;
  logic signed_r, r_valid, accept, last_rd, last_wr;
  logic [ACC_WIDTH-1:0] acc [NUM_LANE];
  assign accept  = state == S_IDLE && i_run;
  assign last_rd = rd_cnt == num_cnt - CNT_BIT'(1);
  assign last_wr = wr_cnt == WW'(NUM_LANE - 1);
  always_comb
    next = state == S_IDLE  ? (i_run ? (i_num_cnt != '0 ? S_READ : S_DONE) : S_IDLE) :
           state == S_READ  ? (last_rd ? S_DRAIN : S_READ) :
           state == S_DRAIN ? S_WRITE :
           state == S_WRITE ? (last_wr ? S_DONE : S_WRITE) : S_IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= S_IDLE;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      num_cnt <= '0;
      wr_base <= '0;
      signed_r <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      state   <= next;
      r_valid <= state == S_READ;
      rd_cnt  <= accept ? '0 : state == S_READ ? rd_cnt + CNT_BIT'(1) : rd_cnt;
      wr_cnt  <= accept ? '0 : state == S_WRITE ? wr_cnt + WW'(1) : wr_cnt;
      if (accept) begin
        num_cnt  <= i_num_cnt;
        wr_base  <= i_wr_base;
        signed_r <= i_signed;
      end
    end
  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    fc_mac_lane #(.IN_DATA_WIDTH(IN_DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk(clk),
      .reset_n(reset_n),
      .i_clr(accept),
      .i_valid(r_valid),
      .i_signed(signed_r),
      .i_node(b0.q[slice_lo(k, NUM_LANE, IN_DATA_WIDTH) +: IN_DATA_WIDTH]),
      .i_wegt(b1.q[slice_lo(k, NUM_LANE, IN_DATA_WIDTH) +: IN_DATA_WIDTH]),
      .o_acc(acc[k])
    );
    assign o_result[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
  end
  assign o_idle  = state == S_IDLE;
  assign o_read  = state == S_READ;
  assign o_write = state == S_WRITE;
  assign o_done  = state == S_DONE;
  assign b0.addr = rd_cnt[AWIDTH-1:0];
  assign b0.ce   = o_read;
  assign b0.we   = 1'b0;
  assign b0.d    = '0;
  assign b1.addr = rd_cnt[AWIDTH-1:0];
  assign b1.ce   = o_read;
  assign b1.we   = 1'b0;
  assign b1.d    = '0;
  assign b2.addr = wr_base + AWIDTH'(wr_cnt);
  assign b2.ce   = o_write;
  assign b2.we   = o_write;
  assign b2.d    = acc[wr_cnt];
endmodule

// File: tb/tb_fc_data_mover_nlane.sv
// tb_fc_data_mover_nlane: directed checks of run latency, MAC results, write-back, run rules and reset abort.
module tb_fc_data_mover_nlane;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_run = 1'b0;
  logic [30:0] i_num_cnt = '0;
  logic i_signed = 1'b0;
  logic [11:0] i_wr_base = '0;
  logic o_idle, o_read, o_write, o_done;
  logic [127:0] o_result;
  int total = 0;
  int bad = 0;
  int done_cyc;
  int nwr, nce0, nce1, nce2;
  logic [11:0] wa [16];
  logic [31:0] wd [16];
  fc_data_mover_nlane_if #(.AWIDTH(12), .DWIDTH(32)) b0 ();
  fc_data_mover_nlane_if #(.AWIDTH(12), .DWIDTH(32)) b1 ();
  fc_data_mover_nlane_if #(.AWIDTH(12), .DWIDTH(32)) b2 ();
  fc_data_mover_nlane dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .i_signed(i_signed), .i_wr_base(i_wr_base), .o_idle(o_idle), .o_read(o_read),
    .o_write(o_write), .o_done(o_done), .b0(b0.master), .b1(b1.master), .b2(b2.master),
    .o_result(o_result)
  );
  always #5 clk = ~clk;
  assign b2.q = '0;
  always @(negedge clk) begin
    if (b0.ce === 1'b1) nce0++;
    if (b1.ce === 1'b1) nce1++;
    if (b2.ce === 1'b1) nce2++;
    if (b2.ce === 1'b1 && b2.we === 1'b1) begin
      if (nwr < 16) begin
        wa[nwr] = b2.addr;
        wd[nwr] = b2.d;
      end
      nwr++;
    end
  end
  task automatic do_run(input int n, input bit sg, input logic [11:0] base, input int pulse_at);
    nwr = 0; nce0 = 0; nce1 = 0; nce2 = 0;
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = 31'(n); i_signed = sg; i_wr_base = base;
    @(negedge clk);
    i_run = 1'b0;
    done_cyc = 1;
    while (o_done !== 1'b1 && done_cyc < 100) begin
      @(negedge clk);
      done_cyc++;
      if (done_cyc == pulse_at) begin
        i_run = 1'b1; i_num_cnt = 31'd8;
      end else i_run = 1'b0;
    end
    i_run = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b exp=1", o_idle); end
    total++; if ({b0.ce, b1.ce, b2.ce, b2.we, o_done} !== 5'b0) begin bad++; $display("FAIL reset_ce got=%0b exp=0", {b0.ce, b1.ce, b2.ce, b2.we, o_done}); end
    total++; if (o_result !== 128'h0) begin bad++; $display("FAIL reset_result got=%0h exp=0", o_result); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_basic(input logic [11:0] base, input int pulse_at);
    b0.q = 32'h01020304; b1.q = 32'h01010101;
    do_run(4, 1'b0, base, pulse_at);
    total++; if (done_cyc !== 10) begin bad++; $display("FAIL basic_latency got=%0d exp=10", done_cyc); end
    total++; if (nce0 !== 4 || nce1 !== 4) begin bad++; $display("FAIL basic_reads got=%0d/%0d exp=4", nce0, nce1); end
    total++; if (nwr !== 4) begin bad++; $display("FAIL basic_nwr got=%0d exp=4", nwr); end
    for (int i = 0; i < 4; i++) begin
      total++; if (wa[i] !== base + 12'(i)) begin bad++; $display("FAIL basic_addr%0d got=%0d exp=%0d", i, wa[i], base + 12'(i)); end
      total++; if (wd[i] !== 32'(4 * (i + 1))) begin bad++; $display("FAIL basic_data%0d got=%0d exp=%0d", i, wd[i], 4 * (i + 1)); end
    end
    total++; if (o_result !== {32'd16, 32'd12, 32'd8, 32'd4}) begin bad++; $display("FAIL basic_result got=%0h exp=00000010_0000000c_00000008_00000004", o_result); end
    repeat (2) @(negedge clk);
    total++; if (o_result !== {32'd16, 32'd12, 32'd8, 32'd4} || o_idle !== 1'b1) begin bad++; $display("FAIL basic_hold got=%0h idle=%0b exp=hold idle=1", o_result, o_idle); end
  endtask
  task automatic test_signed;
    b0.q = 32'hFFFFFFFF; b1.q = 32'h02020202;
    do_run(3, 1'b1, 12'h20, 0);
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL signed_latency got=%0d exp=9", done_cyc); end
    total++; if (o_result !== {4{32'hFFFFFFFA}}) begin bad++; $display("FAIL signed_result got=%0h exp=fffffffa x4", o_result); end
    total++; if (nwr !== 4 || wd[0] !== 32'hFFFFFFFA || wd[3] !== 32'hFFFFFFFA) begin bad++; $display("FAIL signed_write got=%0d %0h %0h exp=4 fffffffa", nwr, wd[0], wd[3]); end
    do_run(3, 1'b0, 12'h20, 0);
    total++; if (o_result !== {4{32'd1530}}) begin bad++; $display("FAIL unsigned_result got=%0h exp=1530 x4", o_result); end
    total++; if (nwr !== 4 || wd[1] !== 32'd1530 || wa[2] !== 12'h22) begin bad++; $display("FAIL unsigned_write got=%0d %0d %0h exp=4 1530 22", nwr, wd[1], wa[2]); end
  endtask
  task automatic test_zero;
    do_run(0, 1'b0, 12'h30, 0);
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", done_cyc); end
    total++; if (nce0 + nce1 + nce2 !== 0) begin bad++; $display("FAIL zero_ce got=%0d exp=0", nce0 + nce1 + nce2); end
    total++; if (o_result !== 128'h0) begin bad++; $display("FAIL zero_result got=%0h exp=0", o_result); end
  endtask
  task automatic test_reset_mid;
    b0.q = 32'h01020304; b1.q = 32'h01010101;
    nwr = 0;
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = 31'd4; i_signed = 1'b0; i_wr_base = 12'h40;
    @(negedge clk);
    i_run = 1'b0;
    @(negedge clk);
    total++; if (o_read !== 1'b1) begin bad++; $display("FAIL mid_in_read got=%0b exp=1", o_read); end
    reset_n = 1'b0;
    #1;
    total++; if (o_idle !== 1'b1 || o_read !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0b exp=1", o_idle); end
    total++; if ({b0.ce, b1.ce, b2.ce, b2.we} !== 4'b0) begin bad++; $display("FAIL mid_ce got=%0b exp=0", {b0.ce, b1.ce, b2.ce, b2.we}); end
    repeat (3) @(negedge clk);
    total++; if (o_result !== 128'h0 || nwr !== 0) begin bad++; $display("FAIL mid_abort got=%0h nwr=%0d exp=0", o_result, nwr); end
    reset_n = 1'b1;
    test_basic(12'h40, 0);
  endtask
  task automatic test_wrap;
    b0.q = 32'h01020304; b1.q = 32'h01010101;
    do_run(4, 1'b0, 12'd4094, 0);
    total++; if (nwr !== 4 || wa[0] !== 12'd4094 || wa[1] !== 12'd4095 || wa[2] !== 12'd0 || wa[3] !== 12'd1) begin bad++; $display("FAIL wrap_addr got=%0d %0d %0d %0d exp=4094 4095 0 1", wa[0], wa[1], wa[2], wa[3]); end
    total++; if (wd[3] !== 32'd16) begin bad++; $display("FAIL wrap_data got=%0d exp=16", wd[3]); end
  endtask
  initial begin
    b0.q = '0; b1.q = '0;
    nwr = 0; nce0 = 0; nce1 = 0; nce2 = 0;
    test_reset;
    test_basic(12'h10, 0);
    test_signed;
    test_zero;
    test_basic(12'h10, 3);
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
